pipe_hazard_ctrl: RTL and testbench

Pipeline stall/flush sequencer for the 5-stage RV32 core. It sits beside the forwarding network and decides, every cycle, which pipeline registers hold, which get bubbles and which get flushed. The causes are data-memory wait states, multi-cycle mul/div occupancy, EX-stage redirects and load-use hazards that forwarding cannot cover. It also keeps a stall watchdog and performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: arbitrates memory wait
// states, mul/div occupancy, EX redirects and load-use hazards each cycle.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_muldiv,
  input  logic                  muldiv_done,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  muldiv_start,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic                  memwb_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  redirect_take,
  output logic                  mem_err,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_HOLD} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] wd_reg, wd_next;
  logic        mem_err_reg;
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  logic mem_stall, load_use, md_wait, start_c;

  always_comb begin
    mem_stall = mem_req && !mem_ready;
    load_use  = id_valid && ex_is_load && ex_wb_en && (ex_rd != '0) &&
                ((id_uses_rs1 && id_rs1_addr == ex_rd) ||
                 (id_uses_rs2 && id_rs2_addr == ex_rd));
    md_wait   = (state_reg == MD_BUSY && !muldiv_done) ||
                (state_reg == MD_HOLD && mem_stall);
    start_c   = (state_reg == RUN) && ex_muldiv && !mem_stall;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (start_c && !muldiv_done) state_next = MD_BUSY;
      MD_BUSY: if (muldiv_done) state_next = mem_stall ? MD_HOLD : RUN;
      MD_HOLD: if (!mem_stall) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Priority chain; a deferred redirect simply re-presents once md_wait drops.
  always_comb begin
    muldiv_start  = 1'b0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_stall    = 1'b0;
    exmem_stall   = 1'b0;
    idex_bubble   = 1'b0;
    exmem_bubble  = 1'b0;
    memwb_bubble  = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_take = 1'b0;
    if (!rst) begin
      muldiv_start = start_c;
      if (mem_stall) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (md_wait) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_bubble = 1'b1;
      end else if (ex_redirect) begin
        redirect_take = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Watchdog counts consecutive memory-stall cycles and saturates at the limit.
  always_comb begin
    wd_next = '0;
    if (mem_stall) wd_next = (wd_reg == TIMEOUT) ? wd_reg : wd_reg + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      wd_reg        <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      if (wd_next == TIMEOUT) mem_err_reg <= 1'b1;
      if (pc_stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (redirect_take) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign mem_err   = mem_err_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle vectors in RUN
// followed by hand-written multi-cycle sequences (mul/div, MD_HOLD, watchdog, reset).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, ex_is_load, ex_wb_en;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd;
  logic        ex_muldiv, muldiv_done, ex_redirect, mem_req, mem_ready;
  logic        muldiv_start, pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic        idex_bubble, exmem_bubble, memwb_bubble;
  logic        ifid_flush, idex_flush, redirect_take, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
    .ex_muldiv(ex_muldiv), .muldiv_done(muldiv_done), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .muldiv_start(muldiv_start), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .exmem_stall(exmem_stall), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .redirect_take(redirect_take),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {start, pc_st, ifid_st, idex_st, exmem_st, idex_bub, exmem_bub, memwb_bub, ifid_fl, idex_fl, redir}
  logic [10:0] outs;
  assign outs = {muldiv_start, pc_stall, ifid_stall, idex_stall, exmem_stall,
                 idex_bubble, exmem_bubble, memwb_bubble,
                 ifid_flush, idex_flush, redirect_take};

  localparam logic [10:0] O_NONE = 11'b000_0000_0000;
  localparam logic [10:0] O_LU   = 11'b011_0010_0000;
  localparam logic [10:0] O_MS   = 11'b011_1100_1000;
  localparam logic [10:0] O_MDW  = 11'b011_1001_0000;
  localparam logic [10:0] O_RD   = 11'b000_0000_0111;
  localparam logic [10:0] O_ST   = 11'b100_0000_0000;

  typedef struct {
    logic       id_valid;
    logic [4:0] rs1, rs2;
    logic       use1, use2, is_load, wb_en;
    logic [4:0] rd;
    logic       muldiv, done, redirect, mreq, mrdy;
    logic [10:0] exp;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  function automatic vec_t mk(logic v, logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
                              logic ld, logic wb, logic [4:0] rd, logic md, logic dn,
                              logic rdr, logic mq, logic my, logic [10:0] e);
    vec_t t;
    t.id_valid = v;  t.rs1 = r1;  t.rs2 = r2;  t.use1 = u1;  t.use2 = u2;
    t.is_load = ld;  t.wb_en = wb; t.rd = rd;  t.muldiv = md; t.done = dn;
    t.redirect = rdr; t.mreq = mq; t.mrdy = my; t.exp = e;
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.id_valid; id_rs1_addr = t.rs1; id_rs2_addr = t.rs2;
    id_uses_rs1 = t.use1; id_uses_rs2 = t.use2; ex_is_load = t.is_load;
    ex_wb_en = t.wb_en; ex_rd = t.rd; ex_muldiv = t.muldiv; muldiv_done = t.done;
    ex_redirect = t.redirect; mem_req = t.mreq; mem_ready = t.mrdy;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 3 units later.
  task automatic step(string name, logic [10:0] exp);
    #3;
    chk(name, {21'd0, outs}, {21'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[16];
  vec_t idle;
  int   exp_stall, exp_flush;

  initial begin
    idle = mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0, O_NONE);
    tbl[0]  = idle;
    tbl[1]  = mk(1,5,0,1,0, 1,1,5, 0,0, 0,0,0, O_LU);    // rs1 load-use
    tbl[2]  = mk(1,0,0,1,0, 1,1,0, 0,0, 0,0,0, O_NONE);  // rd = x0
    tbl[3]  = mk(1,3,7,1,1, 1,1,7, 0,0, 0,0,0, O_LU);    // rs2 load-use
    tbl[4]  = mk(1,3,7,1,0, 1,1,7, 0,0, 0,0,0, O_NONE);  // rs2 not read
    tbl[5]  = mk(0,5,0,1,0, 1,1,5, 0,0, 0,0,0, O_NONE);  // ID empty
    tbl[6]  = mk(1,5,0,1,0, 1,0,5, 0,0, 0,0,0, O_NONE);  // load without writeback
    tbl[7]  = mk(1,5,0,1,0, 0,1,5, 0,0, 0,0,0, O_NONE);  // ALU op, forwarded
    tbl[8]  = mk(1,5,0,1,0, 1,1,5, 0,0, 1,0,0, O_RD);    // redirect beats load-use
    tbl[9]  = mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,0, O_MS);    // mem stall beats redirect
    tbl[10] = mk(1,5,0,1,0, 1,1,5, 0,0, 0,1,0, O_MS);    // mem stall beats load-use
    tbl[11] = mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,1, O_RD);    // ready handshake, no stall
    tbl[12] = mk(0,0,0,0,0, 0,0,0, 1,1, 0,0,0, O_ST);    // mul/div done same cycle
    tbl[13] = mk(0,0,0,0,0, 0,0,0, 1,0, 0,1,0, O_MS);    // no start under mem stall
    tbl[14] = idle;                                      // still in RUN
    tbl[15] = mk(1,9,9,0,1, 1,1,9, 0,0, 0,1,1, O_LU);

    // Reset: outputs forced low even with a load-use and a mem stall presented
    drive(mk(1,5,0,1,0, 1,1,5, 0,0, 0,1,0, O_NONE));
    rst = 1'b1;
    #12;
    chk("rst_outs", {21'd0, outs}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    drive(idle);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven single-cycle vectors
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      if (tbl[i].exp[9]) exp_stall++;
      if (tbl[i].exp[0]) exp_flush++;
      step($sformatf("vec%0d", i), tbl[i].exp);
    end
    drive(idle);
    #1;
    chk("tbl_stall_cnt", stall_cnt, 32'(exp_stall));
    chk("tbl_flush_cnt", flush_cnt, 32'(exp_flush));

    // Load-use costs one bubble, then the load has left EX
    do_reset();
    drive(mk(1,5,0,1,0, 1,1,5, 0,0, 0,0,0, O_NONE));
    step("lu_bubble", O_LU);
    drive(mk(1,5,0,1,0, 0,0,0, 0,0, 0,0,0, O_NONE));
    step("lu_after", O_NONE);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Redirect and load-use together
    do_reset();
    drive(mk(1,5,0,1,0, 1,1,5, 0,0, 1,0,0, O_NONE));
    step("rd_vs_lu", O_RD);
    drive(idle);
    #1;
    chk("rd_flush_cnt", flush_cnt, 32'd1);
    chk("rd_stall_cnt", stall_cnt, 32'd0);

    // Mul/div: start pulse, 4 wait cycles, release on done
    do_reset();
    drive(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0, O_NONE));
    step("md_start", O_ST);
    for (int i = 0; i < 4; i++) step($sformatf("md_wait%0d", i), O_MDW);
    muldiv_done = 1'b1;
    step("md_release", O_NONE);
    drive(idle);
    step("md_run", O_NONE);
    chk("md_stall_cnt", stall_cnt, 32'd4);

    // Mem stall while busy, done arrives mid-stall -> MD_HOLD, then release
    do_reset();
    drive(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0, O_NONE));
    step("hold_start", O_ST);
    step("hold_wait0", O_MDW);
    step("hold_wait1", O_MDW);
    mem_req = 1'b1; mem_ready = 1'b0;
    step("hold_ms0", O_MS);
    muldiv_done = 1'b1;
    step("hold_ms_done", O_MS);
    muldiv_done = 1'b0;
    step("hold_ms1", O_MS);
    mem_ready = 1'b1;
    step("hold_release", O_NONE);
    drive(idle);
    step("hold_run", O_NONE);
    chk("hold_stall_cnt", stall_cnt, 32'd5);

    // Watchdog (limit 8) with a redirect held through a 10-cycle stall
    do_reset();
    drive(mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,0, O_NONE));
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("wd_err_c%0d", i), {31'd0, mem_err}, (i <= 8) ? 32'd0 : 32'd1);
      step($sformatf("wd_ms%0d", i), O_MS);
    end
    mem_ready = 1'b1;
    step("wd_redirect", O_RD);
    drive(idle);
    step("wd_idle", O_NONE);
    chk("wd_err_sticky", {31'd0, mem_err}, 32'd1);
    chk("wd_flush_cnt", flush_cnt, 32'd1);
    chk("wd_stall_cnt", stall_cnt, 32'd10);

    // Asynchronous reset while in MD_BUSY
    drive(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0, O_NONE));
    step("ar_start", O_ST);
    step("ar_wait0", O_MDW);
    #3;
    chk("ar_wait1", {21'd0, outs}, {21'd0, O_MDW});
    rst = 1'b1;
    ex_muldiv = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    chk("ar_outs", {21'd0, outs}, 32'd0);
    chk("ar_stall_cnt", stall_cnt, 32'd0);
    chk("ar_flush_cnt", flush_cnt, 32'd0);
    chk("ar_mem_err", {31'd0, mem_err}, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    muldiv_done = 1'b1;
    step("ar_stale_done", O_NONE);
    drive(idle);
    step("ar_run", O_NONE);
    chk("ar_cnt_after", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
